// File: rtl/chain_pkg.sv
// Shared types and constants for the chain relaxation pipeline.
// Imported by the sweeper, constraint and integrator stages.
package chain_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        APPLY,
        DONE
    } sweep_state_t;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_MULT = 2'b10;

    // Chain ends are anchored and never relaxed.
    function automatic logic is_pinned(input int idx, input int n_points);
        return (idx == 0) || (idx == n_points - 1);
    endfunction

endpackage

// File: rtl/point_regfile.sv
// Chain point store: one write port, three neighbour reads around idx,
// and one readback read. Out-of-range reads return zero.
module point_regfile
    import chain_pkg::*;
#(
    parameter int N_POINTS = 16,
    parameter int ADDR_W   = 4,
    parameter int WORD_W   = chain_pkg::WORD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wx,
    input  logic [WORD_W-1:0] wy,
    input  logic [ADDR_W-1:0] idx,
    output logic [WORD_W-1:0] up_x,
    output logic [WORD_W-1:0] up_y,
    output logic [WORD_W-1:0] mid_x,
    output logic [WORD_W-1:0] mid_y,
    output logic [WORD_W-1:0] dn_x,
    output logic [WORD_W-1:0] dn_y,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rx,
    output logic [WORD_W-1:0] ry
);

    logic [WORD_W-1:0] px [N_POINTS];
    logic [WORD_W-1:0] py [N_POINTS];

    logic [ADDR_W-1:0] a_up;
    logic [ADDR_W-1:0] a_dn;

    assign a_up = idx - ADDR_W'(1);
    assign a_dn = idx + ADDR_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_POINTS; i++) begin
                px[i] <= '0;
                py[i] <= '0;
            end
        end else if (we && (int'(waddr) < N_POINTS)) begin
            px[waddr] <= wx;
            py[waddr] <= wy;
        end
    end

    always_comb begin
        up_x  = '0;
        up_y  = '0;
        mid_x = '0;
        mid_y = '0;
        dn_x  = '0;
        dn_y  = '0;
        rx    = '0;
        ry    = '0;
        if (int'(a_up) < N_POINTS) begin
            up_x = px[a_up];
            up_y = py[a_up];
        end
        if (int'(idx) < N_POINTS) begin
            mid_x = px[idx];
            mid_y = py[idx];
        end
        if (int'(a_dn) < N_POINTS) begin
            dn_x = px[a_dn];
            dn_y = py[a_dn];
        end
        if (int'(raddr) < N_POINTS) begin
            rx = px[raddr];
            ry = py[raddr];
        end
    end

endmodule

// File: rtl/constraint_sweeper.sv
// Gauss-Seidel sequencer: walks interior chain points through the
// external constraint datapath and writes each result back in place.
module constraint_sweeper
    import chain_pkg::*;
#(
    parameter int N_POINTS = 16,
    parameter int ADDR_W   = 4,
    parameter int ITER_W   = 4,
    parameter int WORD_W   = chain_pkg::WORD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_x,
    input  logic [WORD_W-1:0] wr_y,
    input  logic              start,
    input  logic [ITER_W-1:0] iterations,
    output logic              busy,
    output logic              done,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_x,
    output logic [WORD_W-1:0] rd_y,
    output logic [WORD_W-1:0] c_up_x,
    output logic [WORD_W-1:0] c_up_y,
    output logic [WORD_W-1:0] c_x,
    output logic [WORD_W-1:0] c_y,
    output logic [WORD_W-1:0] c_down_x,
    output logic [WORD_W-1:0] c_down_y,
    input  logic [WORD_W-1:0] c_res_x,
    input  logic [WORD_W-1:0] c_res_y
);

    localparam int LAST_IDX = N_POINTS - 2;

    sweep_state_t state, state_n;

    logic [ADDR_W-1:0] idx, idx_n;
    logic [ITER_W-1:0] iter_left, iter_n;

    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [WORD_W-1:0] rf_wx;
    logic [WORD_W-1:0] rf_wy;
    logic              load_c;

    logic [WORD_W-1:0] up_x, up_y, mid_x, mid_y, dn_x, dn_y;
    logic [WORD_W-1:0] rx, ry;

    point_regfile #(
        .N_POINTS (N_POINTS),
        .ADDR_W   (ADDR_W),
        .WORD_W   (WORD_W)
    ) u_regfile (
        .clk   (clk),
        .reset (reset),
        .we    (rf_we),
        .waddr (rf_waddr),
        .wx    (rf_wx),
        .wy    (rf_wy),
        .idx   (idx),
        .up_x  (up_x),
        .up_y  (up_y),
        .mid_x (mid_x),
        .mid_y (mid_y),
        .dn_x  (dn_x),
        .dn_y  (dn_y),
        .raddr (rd_addr),
        .rx    (rx),
        .ry    (ry)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            iter_left <= '0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            iter_left <= iter_n;
        end
    end

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        iter_n   = iter_left;
        rf_we    = 1'b0;
        rf_waddr = wr_addr;
        rf_wx    = wr_x;
        rf_wy    = wr_y;
        load_c   = 1'b0;
        unique case (state)
            IDLE: begin
                rf_we = wr_en;
                if (start) begin
                    idx_n  = ADDR_W'(1);
                    iter_n = iterations;
                    if (iterations == '0) begin
                        state_n = DONE;
                    end else begin
                        state_n = FETCH;
                    end
                end
            end
            FETCH: begin
                load_c  = 1'b1;
                state_n = APPLY;
            end
            APPLY: begin
                rf_we    = !is_pinned(int'(idx), N_POINTS);
                rf_waddr = idx;
                rf_wx    = c_res_x;
                rf_wy    = c_res_y;
                if (int'(idx) < LAST_IDX) begin
                    idx_n   = idx + ADDR_W'(1);
                    state_n = FETCH;
                end else if (iter_left > ITER_W'(1)) begin
                    iter_n  = iter_left - ITER_W'(1);
                    idx_n   = ADDR_W'(1);
                    state_n = FETCH;
                end else begin
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_up_x   <= '0;
            c_up_y   <= '0;
            c_x      <= '0;
            c_y      <= '0;
            c_down_x <= '0;
            c_down_y <= '0;
        end else if (load_c) begin
            c_up_x   <= up_x;
            c_up_y   <= up_y;
            c_x      <= mid_x;
            c_y      <= mid_y;
            c_down_x <= dn_x;
            c_down_y <= dn_y;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_x <= '0;
            rd_y <= '0;
        end else begin
            rd_x <= rx;
            rd_y <= ry;
        end
    end

    assign busy = (state == FETCH) || (state == APPLY);
    assign done = (state == DONE);

endmodule

// File: tb/tb_constraint_sweeper.sv
// Scoreboard bench for constraint_sweeper with a stub constraint
// datapath selectable between passthrough, ordering and averaging.
module tb_constraint_sweeper;

    localparam int N  = 16;
    localparam int AW = 4;
    localparam int IW = 4;
    localparam int WW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [WW-1:0] wr_x = '0;
    logic [WW-1:0] wr_y = '0;
    logic          start = 1'b0;
    logic [IW-1:0] iterations = '0;
    logic          busy;
    logic          done;
    logic [AW-1:0] rd_addr = '0;
    logic [WW-1:0] rd_x, rd_y;
    logic [WW-1:0] c_up_x, c_up_y, c_x, c_y, c_down_x, c_down_y;
    logic [WW-1:0] c_res_x, c_res_y;

    int mode = 0;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int busy_cnt = 0;
    bit done_seen = 1'b0;
    logic rd_req = 1'b0;
    logic rd_v = 1'b0;

    typedef struct {
        int          addr;
        logic [WW-1:0] x;
        logic [WW-1:0] y;
    } rd_exp_t;

    rd_exp_t rq[$];
    int      dq[$];

    constraint_sweeper #(
        .N_POINTS (N),
        .ADDR_W   (AW),
        .ITER_W   (IW),
        .WORD_W   (WW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_x       (wr_x),
        .wr_y       (wr_y),
        .start      (start),
        .iterations (iterations),
        .busy       (busy),
        .done       (done),
        .rd_addr    (rd_addr),
        .rd_x       (rd_x),
        .rd_y       (rd_y),
        .c_up_x     (c_up_x),
        .c_up_y     (c_up_y),
        .c_x        (c_x),
        .c_y        (c_y),
        .c_down_x   (c_down_x),
        .c_down_y   (c_down_y),
        .c_res_x    (c_res_x),
        .c_res_y    (c_res_y)
    );

    always #5 clk = ~clk;

    always_comb begin
        c_res_x = c_x;
        c_res_y = c_y;
        if (mode == 1) begin
            c_res_x = c_up_x + 32'h0001_0000;
            c_res_y = c_y;
        end else if (mode == 2) begin
            c_res_x = (c_up_x + c_down_x) >> 1;
            c_res_y = (c_up_y + c_down_y) >> 1;
        end
    end

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        rd_v <= rd_req;
    end

    // Monitor: readback and done events are checked against the queues.
    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (done) begin
            done_seen = 1'b1;
            checks++;
            if (dq.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected cyc=%0d", cyc);
            end else begin
                int e;
                e = dq.pop_front();
                if (cyc != e) begin
                    errors++;
                    $display("FAIL done_cycle got %0d want %0d", cyc, e);
                end
            end
        end
        if (rd_v) begin
            checks++;
            if (rq.size() == 0) begin
                errors++;
                $display("FAIL readback_unexpected");
            end else begin
                rd_exp_t r;
                r = rq.pop_front();
                if (rd_x !== r.x || rd_y !== r.y) begin
                    errors++;
                    $display("FAIL readback[%0d] got %h/%h want %h/%h",
                             r.addr, rd_x, rd_y, r.x, r.y);
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic load(input int a, input logic [WW-1:0] x,
                        input logic [WW-1:0] y);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_x    = x;
        wr_y    = y;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic read_chk(input int a, input logic [WW-1:0] x,
                            input logic [WW-1:0] y);
        rd_exp_t r;
        r.addr = a;
        r.x = x;
        r.y = y;
        rq.push_back(r);
        rd_addr = AW'(a);
        rd_req  = 1'b1;
        @(negedge clk);
        rd_req  = 1'b0;
    endtask

    task automatic sweep(input int k, input int done_at);
        done_seen  = 1'b0;
        busy_cnt   = 0;
        iterations = IW'(k);
        start      = 1'b1;
        if (done_at >= 0) dq.push_back(cyc + done_at);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done_seen && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (!done_seen) begin
            errors++;
            $display("FAIL done_timeout budget=%0d", budget);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) read_chk(i, '0, '0);

        // Abort mid-sweep
        for (int i = 0; i < N; i++) load(i, WW'(i + 1), WW'(i + 7));
        sweep(3, -1);
        repeat (9) @(negedge clk);
        chk("pre_abort_busy", int'(busy), 1);
        reset = 1'b1;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < N; i++) read_chk(i, '0, '0);

        // Gauss-Seidel ordering, single pass
        mode = 1;
        for (int i = 0; i < N; i++) load(i, '0, WW'(i * 3));
        sweep(1, 29);
        wait_done(100);
        chk("k1_busy_cycles", busy_cnt, 28);
        for (int i = 0; i < N; i++)
            read_chk(i, (i == 0 || i == N - 1) ? '0 : WW'(i * 32'h1_0000),
                     WW'(i * 3));

        // Two passes, second is idempotent
        for (int i = 0; i < N; i++) load(i, '0, '0);
        sweep(2, 57);
        wait_done(150);
        chk("k2_busy_cycles", busy_cnt, 56);
        for (int i = 0; i < N; i++)
            read_chk(i, (i == 0 || i == N - 1) ? '0 : WW'(i * 32'h1_0000), '0);

        // Zero iterations
        mode = 0;
        for (int i = 0; i < N; i++) load(i, WW'(i), '0);
        sweep(0, 1);
        wait_done(10);
        chk("k0_busy_cycles", busy_cnt, 0);
        for (int i = 0; i < N; i++) read_chk(i, WW'(i), '0);

        // Writes and restart attempts during a sweep are dropped
        mode = 1;
        for (int i = 0; i < N; i++) load(i, '0, '0);
        sweep(1, 29);
        repeat (18) @(negedge clk);
        wr_en = 1'b1;
        wr_addr = AW'(5);
        wr_x = 32'hDEAD_0000;
        wr_y = 32'hDEAD_0000;
        start = 1'b1;
        iterations = IW'(3);
        @(negedge clk);
        wr_addr = AW'(15);
        @(negedge clk);
        wr_en = 1'b0;
        start = 1'b0;
        wait_done(100);
        repeat (70) @(negedge clk);
        chk("no_restart_busy", int'(busy), 0);
        read_chk(5, 32'h0005_0000, '0);
        read_chk(15, '0, '0);

        // Straight chain through an averaging datapath stays put
        mode = 2;
        for (int i = 0; i < N; i++) load(i, WW'(i * 32'h0000_f000), '0);
        sweep(4, 113);
        wait_done(300);
        chk("k4_busy_cycles", busy_cnt, 112);
        for (int i = 0; i < N; i++) read_chk(i, WW'(i * 32'h0000_f000), '0);

        repeat (3) @(negedge clk);
        chk("done_queue_drained", dq.size(), 0);
        chk("read_queue_drained", rq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
